// File: rtl/bc_msg_arbiter_pkg.sv
// Shared definitions for the broadcast message arbiter: message field layout and default sizing.
package bc_msg_arbiter_pkg;

  localparam int unsigned BC_DATA_W    = 32;
  localparam int unsigned BC_STRB_W    = 4;
  localparam int unsigned BC_ADDR_W    = 11;
  localparam int unsigned BC_DATA_LSB  = 0;
  localparam int unsigned BC_STRB_LSB  = BC_DATA_LSB + BC_DATA_W;
  localparam int unsigned BC_ADDR_LSB  = BC_STRB_LSB + BC_STRB_W;
  localparam int unsigned BC_MSG_W     = BC_ADDR_LSB + BC_ADDR_W;

  localparam int unsigned BC_CORE_COUNT = 8;
  localparam int unsigned BC_CORE_ID_W  = 3;

  typedef struct packed {
    logic [BC_ADDR_W-1:0] addr;
    logic [BC_STRB_W-1:0] strb;
    logic [BC_DATA_W-1:0] data;
  } bc_msg_t;

  function automatic logic [BC_MSG_W-1:0] bc_pack(input logic [BC_DATA_W-1:0] data,
                                                  input logic [BC_STRB_W-1:0] strb,
                                                  input logic [BC_ADDR_W-1:0] addr);
    bc_msg_t m;
    m.addr = addr;
    m.strb = strb;
    m.data = data;
    return m;
  endfunction

endpackage

// File: rtl/bc_msg_arbiter_rr.sv
// Round-robin arbiter: search starts one past the last grant; before any grant, index 0 leads.
module rr_arbiter #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic [IW-1:0] ptr
);

  logic started;

  always_comb begin
    int unsigned  first;
    logic [IW-1:0] c;
    grant     = '0;
    grant_idx = '0;
    c         = '0;
    // ptr resets to 0 yet core 0 must lead, so the first search begins at 0 rather than ptr+1
    first     = started ? (32'(ptr) + 32'd1) % N : 32'd0;
    for (int unsigned k = 0; k < N; k++) begin
      c = IW'((first + k) % N);
      if (req[c] && grant == '0) begin
        grant[c]  = 1'b1;
        grant_idx = c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      started <= 1'b0;
    end else if (advance && |req) begin
      ptr     <= grant_idx;
      started <= 1'b1;
    end
  end

endmodule

// File: rtl/bc_msg_arbiter.sv
// Broadcast message arbiter: one holding slot per core, round-robin onto a single broadcast register.
// Optional BC_MSG_STAT_EN adds broadcast and stall counters.
module bc_msg_arbiter
  import bc_msg_arbiter_pkg::*;
#(
  parameter int unsigned CORE_COUNT    = BC_CORE_COUNT,
  parameter int unsigned MSG_WIDTH     = BC_MSG_W,
  parameter int unsigned CORE_ID_WIDTH = BC_CORE_ID_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CORE_COUNT*MSG_WIDTH-1:0] s_bc_msg,
  input  logic [CORE_COUNT-1:0]           s_bc_msg_valid,
  output logic [CORE_COUNT-1:0]           s_bc_msg_ready,
  output logic [MSG_WIDTH-1:0]            m_bc_msg,
  output logic                            m_bc_msg_valid,
  output logic [CORE_ID_WIDTH-1:0]        m_bc_msg_src
`ifdef BC_MSG_STAT_EN
  ,
  output logic [31:0]                     stat_bc_count,
  output logic [31:0]                     stat_stall_count
`endif
);

  logic [MSG_WIDTH-1:0]     slot_msg [CORE_COUNT];
  logic [CORE_COUNT-1:0]    slot_valid;
  logic [CORE_COUNT-1:0]    grant;
  logic [CORE_ID_WIDTH-1:0] grant_idx;
  logic [CORE_ID_WIDTH-1:0] last_grant;
  logic                     any_grant;

  assign any_grant      = |grant;
  assign s_bc_msg_ready = ~slot_valid | grant;

  rr_arbiter #(
    .N  (CORE_COUNT),
    .IW (CORE_ID_WIDTH)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (slot_valid),
    .advance   (any_grant),
    .grant     (grant),
    .grant_idx (grant_idx),
    .ptr       (last_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= '0;
      for (int unsigned i = 0; i < CORE_COUNT; i++) slot_msg[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < CORE_COUNT; i++) begin
        if (s_bc_msg_valid[i] && s_bc_msg_ready[i]) begin
          slot_valid[i] <= 1'b1;
          slot_msg[i]   <= s_bc_msg[i*MSG_WIDTH +: MSG_WIDTH];
        end else if (grant[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_bc_msg       <= '0;
      m_bc_msg_valid <= 1'b0;
    end else begin
      m_bc_msg_valid <= any_grant;
      if (any_grant) m_bc_msg <= slot_msg[grant_idx];
    end
  end

  // The arbiter pointer is loaded with the granted index on the same edge, so it doubles as the source register
  assign m_bc_msg_src = last_grant;

`ifdef BC_MSG_STAT_EN
  logic stall_any;
  assign stall_any = |(s_bc_msg_valid & ~s_bc_msg_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_bc_count    <= '0;
      stat_stall_count <= '0;
    end else begin
      if (any_grant) stat_bc_count <= stat_bc_count + 32'd1;
      if (stall_any && stat_stall_count != '1) stat_stall_count <= stat_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/bc_msg_arbiter.md
BC_MSG_ARBITER -- requirements
Module: bc_msg_arbiter

Interface
REQ-001 Parameter CORE_COUNT, default 8: number of core broadcast sources and sinks.
REQ-002 Parameter MSG_WIDTH, default 47: broadcast message width (32 data + 4 strobe + 11 word address).
REQ-003 Parameter CORE_ID_WIDTH, default 3: source-ID width; SHALL equal clog2(CORE_COUNT).
REQ-004 Port clk, input, 1: single clock for all logic.
REQ-005 Port rst, input, 1: asynchronous active-high reset.
REQ-006 Port s_bc_msg, input, CORE_COUNT*MSG_WIDTH: per-core bc_msg_out, core i at slice [i*MSG_WIDTH +: MSG_WIDTH].
REQ-007 Port s_bc_msg_valid, input, CORE_COUNT: per-core message valid.
REQ-008 Port s_bc_msg_ready, output, CORE_COUNT: per-core accept.
REQ-009 Port m_bc_msg, output, MSG_WIDTH: broadcast message to every core's bc_msg_in.
REQ-010 Port m_bc_msg_valid, output, 1: one-cycle broadcast strobe; no backpressure.
REQ-011 Port m_bc_msg_src, output, CORE_ID_WIDTH: index of the originating core.

Function
REQ-012 Each input SHALL own one holding slot (message plus valid flag).
REQ-013 Accept rule: s_bc_msg_ready[i] = !slot_valid[i] || grant[i]. A beat loads when valid and ready are both high at a rising edge.
REQ-014 At most one grant per cycle, among slots with slot_valid set, by round-robin arbitration.
REQ-015 Round-robin order: search starts at last_grant+1 and wraps from CORE_COUNT-1 to 0.
REQ-016 The pointer updates only on a grant; after reset, core 0 has highest priority.
REQ-017 Granted slot: the message is registered onto m_bc_msg, with m_bc_msg_valid=1 and m_bc_msg_src=index, at the next edge. slot_valid clears unless the same edge refills it.
REQ-018 No grant: m_bc_msg_valid=0 and m_bc_msg holds its previous value.
REQ-019 Latency: a beat accepted at edge k on an otherwise idle arbiter appears at the outputs after edge k+1.
REQ-020 Throughput:
  - aggregate, one broadcast per cycle;
  - a lone active core sustains one message per cycle (slot refill on the grant edge).
REQ-021 Fairness: with all slots continuously full, each core is granted exactly once in every CORE_COUNT consecutive cycles.
REQ-022 Ordering: messages from a single core SHALL be broadcast in acceptance order; no message is dropped or duplicated.
REQ-023 A slot with valid=0 SHALL never be granted, whatever the pointer position.

Reset
REQ-024 While rst is asserted, all of the following SHALL be 0:
  - slot_valid, last_grant;
  - m_bc_msg_valid, m_bc_msg_src, m_bc_msg.
REQ-025 While rst is asserted, s_bc_msg_ready SHALL be all-ones, because slots are empty.
REQ-026 Reset mid-operation discards all held messages; no partial broadcast follows deassertion.
REQ-027 Message data registers SHALL be reset together with valid, not left uninitialised.

Configuration
REQ-028 Macro BC_MSG_STAT_EN defined adds two outputs, both cleared by rst:
  - stat_bc_count, 32-bit: increments on every m_bc_msg_valid, wrapping at 2^32-1 to 0;
  - stat_stall_count, 32-bit: increments each cycle in which any s_bc_msg_valid[i]=1 with s_bc_msg_ready[i]=0, saturating at 2^32-1.
REQ-029 Macro undefined: neither port nor counter exists, and all other behaviour is identical.

Structure
REQ-030 A shared package SHALL hold:
  - the message field widths and offsets (DATA 32, STRB 4, ADDR 11);
  - the default CORE_COUNT and CORE_ID_WIDTH.
REQ-031 The round-robin grant logic SHALL be a sub-module rr_arbiter:
  - inputs: request vector, advance strobe;
  - outputs: one-hot grant, encoded index, registered pointer.
REQ-032 The slots and the output register SHALL live in bc_msg_arbiter.

Verification
REQ-033 Single message: core 5 sends 0x1234_5678/strb F/addr 0x010 at edge 0 -> after edge 1, m_bc_msg_valid=1 for exactly one cycle, m_bc_msg_src=5, fields match.
REQ-034 Contention: all 8 cores hold valid for 16 cycles from reset -> m_bc_msg_src sequence 0,1,...,7,0,...,7 with no gaps.
REQ-035 Streaming: core 2 alone sends 10 back-to-back messages with payloads 0..9 -> s_bc_msg_ready[2] stays 1, and 10 consecutive broadcasts carry 0..9 in order.
REQ-036 Backpressure: cores 0 and 1 stream continuously -> each ready toggles so that broadcasts alternate 0,1,0,1 and the sum of accepted beats equals the sum of broadcasts.
REQ-037 Reset mid-operation: rst is asserted with 3 slots full -> no broadcast follows deassertion, ready returns all-ones, and the next request from core 7 is granted first-round per pointer 0.
REQ-038 BC_MSG_STAT_EN: after REQ-034, stat_bc_count=16; with core 0 valid during a cycle where it lacks the grant, stat_stall_count increments by 1.
